// File: rtl/mips_mc_pkg.sv
// rtl/mips_mc_pkg.sv - shared types and encodings for the multicycle MIPS controller
package mips_mc_pkg;

    typedef enum logic [3:0] {
        S_FETCH,
        S_DECODE,
        S_MEMADR,
        S_MEMRD,
        S_MEMWB,
        S_MEMWR,
        S_EXEC,
        S_ALUWB,
        S_BRANCH,
        S_ADDIEX,
        S_ADDIWB,
        S_JUMP
    } state_t;

    localparam logic [2:0] ALU_ADD = 3'b010;
    localparam logic [2:0] ALU_SUB = 3'b110;
    localparam logic [2:0] ALU_AND = 3'b000;
    localparam logic [2:0] ALU_OR  = 3'b001;
    localparam logic [2:0] ALU_SLT = 3'b111;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_J     = 6'b000010;

    localparam logic [5:0] F_ADD = 6'b100000;
    localparam logic [5:0] F_SUB = 6'b100010;
    localparam logic [5:0] F_AND = 6'b100100;
    localparam logic [5:0] F_OR  = 6'b100101;
    localparam logic [5:0] F_SLT = 6'b101010;

    // States that own the shared memory port and run the wait counter
    function automatic logic is_mem_state(input state_t s);
        return (s == S_FETCH) || (s == S_MEMRD) || (s == S_MEMWR);
    endfunction

endpackage

// File: rtl/mips_alu_decoder.sv
// rtl/mips_alu_decoder.sv - maps R-type funct to ALU operation and a validity flag
module mips_alu_decoder
    import mips_mc_pkg::*;
(
    input  logic [5:0] funct,
    output logic [2:0] alu_ctrl,
    output logic       funct_valid
);

    always_comb begin
        alu_ctrl    = ALU_ADD;
        funct_valid = 1'b1;
        case (funct)
            F_ADD:   alu_ctrl = ALU_ADD;
            F_SUB:   alu_ctrl = ALU_SUB;
            F_AND:   alu_ctrl = ALU_AND;
            F_OR:    alu_ctrl = ALU_OR;
            F_SLT:   alu_ctrl = ALU_SLT;
            default: funct_valid = 1'b0;
        endcase
    end

endmodule

// File: rtl/mips_mc_controller.sv
// rtl/mips_mc_controller.sv - Moore multicycle control unit with shared-memory handshake
module mips_mc_controller
    import mips_mc_pkg::*;
#(
    parameter bit          EN_ADDI  = 1'b1,
    parameter bit          EN_JUMP  = 1'b1,
    parameter bit          EN_BNE   = 1'b0,
    parameter int unsigned WAIT_MAX = 0
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [5:0] opcode,
    input  logic [5:0] funct,
    input  logic       zero,
    input  logic       mem_ready,
    output logic       mem_req,
    output logic       mem_write,
    output logic       iord,
    output logic       ir_write,
    output logic       pc_en,
    output logic [1:0] pc_src,
    output logic       alu_src_a,
    output logic [1:0] alu_src_b,
    output logic [2:0] alu_ctrl,
    output logic       reg_dst,
    output logic       mem_to_reg,
    output logic       reg_write,
    output logic       retire,
    output logic       illegal,
    output logic       timeout
);

    localparam logic [7:0] WAIT_LIM = 8'(WAIT_MAX);

    state_t     state_q, state_d;
    logic [7:0] wait_cnt_q, wait_cnt_d;
    logic [2:0] dec_alu_ctrl;
    logic       funct_valid;
    logic       op_legal;
    logic       wait_expired;

    mips_alu_decoder u_alu_decoder (
        .funct      (funct),
        .alu_ctrl   (dec_alu_ctrl),
        .funct_valid(funct_valid)
    );

    always_comb begin
        op_legal = 1'b0;
        case (opcode)
            OP_LW, OP_SW: op_legal = 1'b1;
            OP_RTYPE:     op_legal = funct_valid;
            OP_BEQ:       op_legal = 1'b1;
            OP_BNE:       op_legal = EN_BNE;
            OP_ADDI:      op_legal = EN_ADDI;
            OP_J:         op_legal = EN_JUMP;
            default:      op_legal = 1'b0;
        endcase
    end

    assign wait_expired = is_mem_state(state_q) && !mem_ready
                          && (WAIT_LIM != 8'd0) && (wait_cnt_q == WAIT_LIM);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= S_FETCH;
            wait_cnt_q <= 8'd0;
        end else begin
            state_q    <= state_d;
            wait_cnt_q <= wait_cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_FETCH:  if (wait_expired) state_d = S_FETCH;
                      else if (mem_ready) state_d = S_DECODE;
            S_DECODE: begin
                if (!op_legal) begin
                    state_d = S_FETCH;
                end else begin
                    case (opcode)
                        OP_LW, OP_SW:   state_d = S_MEMADR;
                        OP_RTYPE:       state_d = S_EXEC;
                        OP_BEQ, OP_BNE: state_d = S_BRANCH;
                        OP_ADDI:        state_d = S_ADDIEX;
                        OP_J:           state_d = S_JUMP;
                        default:        state_d = S_FETCH;
                    endcase
                end
            end
            S_MEMADR: state_d = (opcode == OP_LW) ? S_MEMRD : S_MEMWR;
            S_MEMRD:  if (wait_expired) state_d = S_FETCH;
                      else if (mem_ready) state_d = S_MEMWB;
            S_MEMWR:  if (wait_expired || mem_ready) state_d = S_FETCH;
            S_EXEC:   state_d = S_ALUWB;
            S_ADDIEX: state_d = S_ADDIWB;
            default:  state_d = S_FETCH;
        endcase
    end

    // A timeout in FETCH keeps the state but still counts as a fresh entry
    always_comb begin
        wait_cnt_d = wait_cnt_q;
        if (is_mem_state(state_d) && ((state_d != state_q) || wait_expired)) begin
            wait_cnt_d = 8'd0;
        end else if (is_mem_state(state_q) && !mem_ready && (wait_cnt_q != 8'hFF)) begin
            wait_cnt_d = wait_cnt_q + 8'd1;
        end
    end

    // Everything is forced low while reset is held, which also drops an in-flight request
    always_comb begin
        mem_req    = 1'b0;
        mem_write  = 1'b0;
        iord       = 1'b0;
        ir_write   = 1'b0;
        pc_en      = 1'b0;
        pc_src     = 2'b00;
        alu_src_a  = 1'b0;
        alu_src_b  = 2'b00;
        alu_ctrl   = ALU_AND;
        reg_dst    = 1'b0;
        mem_to_reg = 1'b0;
        reg_write  = 1'b0;
        retire     = 1'b0;
        illegal    = 1'b0;
        timeout    = 1'b0;
        if (reset) begin
            case (state_q)
                S_FETCH: begin
                    mem_req   = 1'b1;
                    alu_src_b = 2'b01;
                    alu_ctrl  = ALU_ADD;
                    timeout   = wait_expired;
                    ir_write  = mem_ready && !wait_expired;
                    pc_en     = mem_ready && !wait_expired;
                end
                S_DECODE: begin
                    alu_src_b = 2'b11;
                    alu_ctrl  = ALU_ADD;
                    illegal   = !op_legal;
                end
                S_MEMADR: begin
                    alu_src_a = 1'b1;
                    alu_src_b = 2'b10;
                    alu_ctrl  = ALU_ADD;
                end
                S_MEMRD: begin
                    mem_req = 1'b1;
                    iord    = 1'b1;
                    timeout = wait_expired;
                end
                S_MEMWB: begin
                    mem_to_reg = 1'b1;
                    reg_write  = 1'b1;
                    retire     = 1'b1;
                end
                S_MEMWR: begin
                    mem_req   = 1'b1;
                    mem_write = 1'b1;
                    iord      = 1'b1;
                    timeout   = wait_expired;
                    retire    = mem_ready && !wait_expired;
                end
                S_EXEC: begin
                    alu_src_a = 1'b1;
                    alu_ctrl  = dec_alu_ctrl;
                end
                S_ALUWB: begin
                    reg_dst   = 1'b1;
                    reg_write = 1'b1;
                    retire    = 1'b1;
                end
                S_BRANCH: begin
                    alu_src_a = 1'b1;
                    alu_ctrl  = ALU_SUB;
                    pc_src    = 2'b01;
                    retire    = 1'b1;
                    pc_en     = (opcode == OP_BNE) ? !zero : zero;
                end
                S_ADDIEX: begin
                    alu_src_a = 1'b1;
                    alu_src_b = 2'b10;
                    alu_ctrl  = ALU_ADD;
                end
                S_ADDIWB: begin
                    reg_write = 1'b1;
                    retire    = 1'b1;
                end
                S_JUMP: begin
                    pc_src = 2'b10;
                    pc_en  = 1'b1;
                    retire = 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: doc/mips_mc_controller.md
# mips_mc_controller

Multicycle control unit for the next-generation MIPS core. It replaces the single-cycle combinational controller with a Moore state machine that sequences fetch, decode, execute, memory and writeback over several cycles against one shared instruction/data memory with a ready handshake. Optional instructions are enabled by parameter. It drives the multicycle datapath's mux selects, register enables and memory strobes, and it flags illegal instructions and memory timeouts.

## Interface
Parameters:
- EN_ADDI, 1: decode addi (opcode 001000); when 0, addi is illegal.
- EN_JUMP, 1: decode j (opcode 000010); when 0, j is illegal.
- EN_BNE, 0: decode bne (opcode 000101); when 0, bne is illegal.
- WAIT_MAX, 0: maximum memory wait cycles before a timeout; 0 means the wait is unlimited. Range is 0..255.

Ports:
- clk  in  1  clock; all state changes on the rising edge.
- reset  in  1  asynchronous, active-low reset (asserted at 0).
- opcode  in  6  instr[31:26] from the instruction register.
- funct  in  6  instr[5:0] from the instruction register.
- zero  in  1  ALU zero flag.
- mem_ready  in  1  memory completes the current access this cycle.
- mem_req  out  1  memory access request.
- mem_write  out  1  the current request is a write.
- iord  out  1  address select: 0 = PC, 1 = ALU result register.
- ir_write  out  1  load the instruction register.
- pc_en  out  1  load the PC.
- pc_src  out  2  PC source: 00 = ALU, 01 = ALU result register, 10 = jump target.
- alu_src_a  out  1  ALU A select: 0 = PC, 1 = register A.
- alu_src_b  out  2  ALU B select: 00 = register B, 01 = 4, 10 = sign-extended immediate, 11 = sign-extended immediate << 2.
- alu_ctrl  out  3  ALU operation: 010 add, 110 sub, 000 and, 001 or, 111 slt.
- reg_dst  out  1  destination register: 0 = rt, 1 = rd.
- mem_to_reg  out  1  writeback source: 0 = ALU result register, 1 = data register.
- reg_write  out  1  register file write enable.
- retire  out  1  one-cycle pulse when an instruction completes.
- illegal  out  1  one-cycle pulse on an unsupported opcode or funct.
- timeout  out  1  one-cycle pulse when a memory access is abandoned.

## Operation
- All outputs are decoded from the state alone, except pc_en and the handshake-qualified strobes.
- Signals not listed for a state are 0.
- States and their outputs:
  - FETCH: mem_req=1, iord=0, alu_src_a=0, alu_src_b=01, alu_ctrl=add, pc_src=00. When mem_ready=1: ir_write=1, pc_en=1, next state DECODE. Otherwise stay in FETCH with no register writes.
  - DECODE: alu_src_a=0, alu_src_b=11, alu_ctrl=add (precomputes the branch target). Next state by opcode:
    - lw (100011) or sw (101011) → MEMADR
    - R-type (000000) with a valid funct → EXEC
    - beq (000100), or bne when EN_BNE=1 → BRANCH
    - addi when EN_ADDI=1 → ADDIEX
    - j when EN_JUMP=1 → JUMP
    - anything else → FETCH, with illegal=1.
  - MEMADR: alu_src_a=1, alu_src_b=10, alu_ctrl=add. lw → MEMRD; sw → MEMWR.
  - MEMRD: mem_req=1, iord=1. mem_ready → MEMWB.
  - MEMWB: reg_dst=0, mem_to_reg=1, reg_write=1, retire=1. Next state FETCH.
  - MEMWR: mem_req=1, mem_write=1, iord=1. mem_ready → FETCH, with retire=1 in that cycle.
  - EXEC: alu_src_a=1, alu_src_b=00, alu_ctrl from funct. Next state ALUWB.
  - ALUWB: reg_dst=1, mem_to_reg=0, reg_write=1, retire=1. Next state FETCH.
  - BRANCH: alu_src_a=1, alu_src_b=00, alu_ctrl=sub, pc_src=01, retire=1. pc_en=zero for beq and ~zero for bne. Next state FETCH.
  - ADDIEX: alu_src_a=1, alu_src_b=10, alu_ctrl=add. Next state ADDIWB.
  - ADDIWB: reg_dst=0, mem_to_reg=0, reg_write=1, retire=1. Next state FETCH.
  - JUMP: pc_src=10, pc_en=1, retire=1. Next state FETCH.
- Funct decode: 100000 add, 100010 sub, 100100 and, 100101 or, 101010 slt. Any other funct is illegal.
- Wait counter (8 bit):
  - Cleared on entry to any memory state (FETCH, MEMRD, MEMWR).
  - Increments on each cycle in a memory state with mem_ready=0.
  - If WAIT_MAX≠0 and the counter equals WAIT_MAX with mem_ready=0: timeout=1, no writes, next state FETCH, and the PC is not advanced.

## Timing
- Cycles per instruction with zero wait states:
  - lw: 5
  - sw: 4
  - R-type: 4
  - addi: 4
  - beq/bne: 3
  - j: 3
  - illegal: 2
- Each memory wait cycle adds 1.
- Reset:
  - While reset=0, the state is FETCH, the counter is 0, and every output is 0 (mem_req is gated by reset).
  - The first request is issued in the cycle after reset rises.
- Reset mid-access abandons the access immediately; no write strobe is asserted after reset falls.
- mem_ready is sampled only in memory states and is ignored elsewhere.
- mem_req stays high, with iord and mem_write stable, until mem_ready=1 or timeout.

## Structure
- Package mips_mc_pkg holds:
  - the state enum (state_t)
  - the alu_ctrl constants
  - the opcode and funct localparams.
- Sub-module mips_alu_decoder is combinational: it maps funct to {alu_ctrl, funct_valid}. DECODE uses it for validity and EXEC uses it for the operation.

## Test plan
- Zero-wait add $3,$1,$2 → FETCH,DECODE,EXEC,ALUWB. reg_write=1 and reg_dst=1 on cycle 4; retire on cycle 4; alu_ctrl=010 in EXEC.
- lw with mem_ready low for 2 cycles in MEMRD → 7 cycles total; mem_req and iord=1 held through the wait; mem_to_reg=1 in MEMWB.
- beq with zero=0, then zero=1 → pc_en=0, then pc_en=1 in BRANCH with pc_src=01. bne with EN_BNE=0 → illegal pulse in DECODE.
- WAIT_MAX=3 with mem_ready held 0 in FETCH → timeout pulse on the 4th wait cycle. ir_write and pc_en stay 0; FETCH is re-entered.
- funct=000011 (unsupported) → illegal=1 in DECODE, reg_write never asserted, next state FETCH.
- reset falls during MEMWR wait → mem_req and mem_write drop to 0 immediately. After release, FETCH with mem_req=1 and iord=0.
